// File: rtl/cla_pkg.sv
// Shared definitions for the slice-serial carry-lookahead adder.
// Holds the controller state encoding and the slice width used by the datapath.
package cla_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla.sv
// 4-bit carry-lookahead adder slice; purely combinational.
// All four carries come from generate/propagate terms rather than a ripple chain.
module cla
  import cla_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W-1:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s = p ^ c;

endmodule

// File: rtl/cla_serial_adder.sv
// Slice-serial adder: one 4-bit CLA reused over WIDTH/4 cycles, valid/ready on both sides.
// Optional macro CLA_SERIAL_OVF_EN adds a registered two's-complement overflow output ovf.
module cla_serial_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CLA_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  state_t             state;
  state_t             next_state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               carry_q;
  logic [CW-1:0]      k;
  logic [SLICE_W-1:0] slice_s;
  logic               slice_c4;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  cla u_cla (
    .a    (a_q[k*SLICE_W +: SLICE_W]),
    .b    (b_q[k*SLICE_W +: SLICE_W]),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_c4)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid)  next_state = RUN;
      RUN:     if (k == LAST) next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The sum register is filled one slice per RUN cycle; it is only exposed once DONE is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      k       <= '0;
      sum     <= '0;
      cout    <= 1'b0;
`ifdef CLA_SERIAL_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            k       <= '0;
          end
        end
        RUN: begin
          sum[k*SLICE_W +: SLICE_W] <= slice_s;
          carry_q                   <= slice_c4;
          k                         <= k + 1'b1;
          if (k == LAST) begin
            cout <= slice_c4;
`ifdef CLA_SERIAL_OVF_EN
            // Same as carry-into-MSB XOR carry-out: like-signed operands giving an opposite-signed sum.
            ovf  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_s[SLICE_W-1] != a_q[WIDTH-1]);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
